// File: rtl/datapath_pipe_if.sv
// Issue, result and debug signals between the decoder/controller (master)
// and the pipelined datapath (slave).
interface datapath_pipe_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4,
    parameter int IMM_W = 8
);
    // Handshake: an instruction is accepted on a rising edge where
    // in_valid & in_ready; in_ready is ~stall and never depends on in_valid.
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic [3:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs_a;
    logic [AW-1:0]    rs_b;
    logic             sel_imm;
    logic [IMM_W-1:0] imm;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [AW-1:0]    res_rd;
    logic [4:0]       flags;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output in_valid, stall, op, rd, rs_a, rs_b, sel_imm, imm, dbg_addr,
        input  in_ready, res_valid, res_data, res_rd, flags, dbg_data
    );

    modport slave (
        input  in_valid, stall, op, rd, rs_a, rs_b, sel_imm, imm, dbg_addr,
        output in_ready, res_valid, res_data, res_rd, flags, dbg_data
    );
endinterface

// File: rtl/datapath_pipe.sv
// Register file + ALU with one registered execute stage, EX->issue operand
// bypass, flag register {C,L,F,Z,N} and a combinational debug read port.
module datapath_pipe #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter int AW      = 4,
    parameter int IMM_W   = 8,
    parameter int R0_ZERO = 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    datapath_pipe_if.slave  bus
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB = 4'd2,  OP_CMP = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_MOV = 4'd7;
    localparam logic [3:0] OP_LSH  = 4'd8,  OP_RSH  = 4'd9,  OP_ARSH = 4'd10, OP_NOT = 4'd11;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic             ex_valid_q, ex_we_q;
    logic [AW-1:0]    ex_rd_q;
    logic [WIDTH-1:0] ex_data_q;
    logic [4:0]       flags_q;

    logic             issue;
    logic [WIDTH-1:0] rf_a, rf_b, rf_dbg;
    logic [WIDTH-1:0] op_a, op_b, b_val;
    logic [WIDTH:0]   sum, diff;
    logic             cin, rd_ok, we_d;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] res_d;
    logic [4:0]       flags_d;

    assign issue = bus.in_valid & ~bus.stall;

    // Loop-based read mux: addresses >= NREGS fall through to 0.
    always_comb begin
        rf_a   = '0;
        rf_b   = '0;
        rf_dbg = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.rs_a == AW'(i))     rf_a   = regs_q[i];
            if (bus.rs_b == AW'(i))     rf_b   = regs_q[i];
            if (bus.dbg_addr == AW'(i)) rf_dbg = regs_q[i];
        end
    end

    // ex_we_q is already cleared for r0/out-of-range targets, so bypass never
    // forwards a dropped write.
    always_comb begin
        op_a = rf_a;
        op_b = rf_b;
        if (ex_valid_q && ex_we_q && ex_rd_q == bus.rs_a) op_a = ex_data_q;
        if (ex_valid_q && ex_we_q && ex_rd_q == bus.rs_b) op_b = ex_data_q;
        if (R0_ZERO != 0 && bus.rs_a == '0) op_a = '0;
        if (R0_ZERO != 0 && bus.rs_b == '0) op_b = '0;
    end

    assign b_val = bus.sel_imm ? WIDTH'($signed(bus.imm)) : op_b;
    assign rd_ok = (int'(bus.rd) < NREGS) && !(R0_ZERO != 0 && bus.rd == '0);

    always_comb begin
        cin     = (bus.op == OP_ADDC) & flags_q[FC];
        sum     = {1'b0, op_a} + {1'b0, b_val} + {{WIDTH{1'b0}}, cin};
        diff    = {1'b0, op_a} - {1'b0, b_val};
        sh      = b_val[SW-1:0];
        res_d   = '0;
        flags_d = flags_q;
        we_d    = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADDC: begin
                res_d       = sum[WIDTH-1:0];
                we_d        = 1'b1;
                flags_d[FC] = sum[WIDTH];
                flags_d[FF] = (op_a[MSB] == b_val[MSB]) && (res_d[MSB] != op_a[MSB]);
                flags_d[FZ] = (res_d == '0);
            end
            OP_SUB, OP_CMP: begin
                res_d       = diff[WIDTH-1:0];
                we_d        = (bus.op == OP_SUB);
                flags_d[FC] = diff[WIDTH];
                flags_d[FL] = diff[WIDTH];
                flags_d[FF] = (op_a[MSB] != b_val[MSB]) && (res_d[MSB] != op_a[MSB]);
                flags_d[FZ] = (op_a == b_val);
                flags_d[FN] = ($signed(op_a) < $signed(b_val));
            end
            OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH, OP_RSH, OP_ARSH, OP_NOT: begin
                we_d = 1'b1;
                case (bus.op)
                    OP_AND:  res_d = op_a & b_val;
                    OP_OR:   res_d = op_a | b_val;
                    OP_XOR:  res_d = op_a ^ b_val;
                    OP_MOV:  res_d = b_val;
                    OP_LSH:  res_d = op_a << sh;
                    OP_RSH:  res_d = op_a >> sh;
                    OP_ARSH: res_d = $unsigned($signed(op_a) >>> sh);
                    default: res_d = ~op_a;
                endcase
                flags_d[FZ] = (res_d == '0);
            end
            default: ;
        endcase
        we_d = we_d & rd_ok;
    end

    // Writeback of the old EX contents and capture of the new issue share one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            ex_valid_q <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_rd_q    <= '0;
            ex_data_q  <= '0;
            flags_q    <= '0;
        end else begin
            if (ex_valid_q && ex_we_q) begin
                for (int i = 0; i < NREGS; i++)
                    if (ex_rd_q == AW'(i)) regs_q[i] <= ex_data_q;
            end
            ex_valid_q <= issue;
            if (issue) begin
                ex_we_q   <= we_d;
                ex_rd_q   <= bus.rd;
                ex_data_q <= res_d;
                flags_q   <= flags_d;
            end
        end
    end

    assign bus.in_ready  = ~bus.stall;
    assign bus.res_valid = ex_valid_q;
    assign bus.res_data  = ex_data_q;
    assign bus.res_rd    = ex_rd_q;
    assign bus.flags     = flags_q;
    assign bus.dbg_data  = rf_dbg;
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: issued ops push {rd,data,flags} into a
// queue that a negedge monitor pops whenever res_valid is high.
module tb_datapath_pipe;
    localparam int WIDTH = 16;
    localparam int AW    = 4;
    localparam int IMM_W = 8;
    localparam int NREGS = 16;
    localparam int W     = AW + WIDTH + 5;

    localparam logic [3:0] ADD = 4'd0, ADDC = 4'd1, SUB = 4'd2, CMP = 4'd3;
    localparam logic [3:0] AND_ = 4'd4, OR_ = 4'd5, XOR_ = 4'd6, MOV = 4'd7;
    localparam logic [3:0] LSH = 4'd8, RSH = 4'd9, ARSH = 4'd10, NOT_ = 4'd11, NOP = 4'd12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    datapath_pipe_if #(.WIDTH(WIDTH), .AW(AW), .IMM_W(IMM_W)) bus ();

    datapath_pipe #(
        .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .IMM_W(IMM_W), .R0_ZERO(1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic sel, input logic [IMM_W-1:0] imm);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rd       = rd;
        bus.rs_a     = ra;
        bus.rs_b     = rb;
        bus.sel_imm  = sel;
        bus.imm      = imm;
    endtask

    task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic sel, input logic [IMM_W-1:0] imm,
                         input logic [WIDTH-1:0] exp_data, input logic [4:0] exp_flags);
        drive(op, rd, ra, rb, sel, imm);
        exp_q.push_back({rd, exp_data, exp_flags});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic dbg_chk(input logic [AW-1:0] addr, input logic [WIDTH-1:0] exp);
        bus.dbg_addr = addr;
        #1;
        check($sformatf("dbg_r%0d", addr), 32'(bus.dbg_data), 32'(exp));
    endtask

    // Monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", 32'(bus.res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_rd",   32'(bus.res_rd),   32'(e[W-1 -: AW]));
                    check("res_data", 32'(bus.res_data), 32'(e[WIDTH+4 -: WIDTH]));
                    check("flags",    32'(bus.flags),    32'(e[4:0]));
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        bus.op       = '0;
        bus.rd       = '0;
        bus.rs_a     = '0;
        bus.rs_b     = '0;
        bus.sel_imm  = 1'b0;
        bus.imm      = '0;
        bus.dbg_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data",  32'(bus.res_data),  32'd0);
        check("rst_res_rd",    32'(bus.res_rd),    32'd0);
        check("rst_flags",     32'(bus.flags),     32'd0);
        rst_n = 1'b1;
        idle(1);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);

        // Reset mid-flight: fill r1..r15, then abort an ADD before its writeback
        for (int r = 1; r < NREGS; r++)
            issue(MOV, AW'(r), 4'd0, 4'd0, 1'b1, 8'hFF, 16'hFFFF, 5'b00000);
        drive(ADD, 4'd1, 4'd1, 4'd2, 1'b0, 8'h00);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_flags",     32'(bus.flags),     32'd0);
        for (int r = 0; r < NREGS; r++) dbg_chk(AW'(r), 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        for (int r = 0; r < NREGS; r++) dbg_chk(AW'(r), 16'h0000);
        idle(1);

        // Bypass
        issue(MOV, 4'd1, 4'd0, 4'd0, 1'b1, 8'h7F, 16'h007F, 5'b00000);
        issue(ADD, 4'd2, 4'd1, 4'd1, 1'b0, 8'h00, 16'h00FE, 5'b00000);
        idle(1);
        dbg_chk(4'd1, 16'h007F);
        dbg_chk(4'd2, 16'h00FE);
        idle(1);

        // Sign extension and shifts
        issue(MOV,  4'd3, 4'd0, 4'd0, 1'b1, 8'h80, 16'hFF80, 5'b00000);
        issue(ARSH, 4'd4, 4'd3, 4'd0, 1'b1, 8'h04, 16'hFFF8, 5'b00000);
        issue(RSH,  4'd5, 4'd3, 4'd0, 1'b1, 8'h04, 16'h0FF8, 5'b00000);
        idle(1);
        dbg_chk(4'd4, 16'hFFF8);
        dbg_chk(4'd5, 16'h0FF8);
        idle(1);

        // Carry chain
        issue(MOV,  4'd6, 4'd0, 4'd0, 1'b1, 8'hFF, 16'hFFFF, 5'b00000);
        issue(MOV,  4'd7, 4'd0, 4'd0, 1'b1, 8'h01, 16'h0001, 5'b00000);
        issue(ADD,  4'd8, 4'd6, 4'd7, 1'b0, 8'h00, 16'h0000, 5'b10010);
        issue(ADDC, 4'd9, 4'd0, 4'd0, 1'b0, 8'h00, 16'h0001, 5'b00000);

        // Compare, NOP, logic ops
        issue(LSH,  4'd10, 4'd7,  4'd0,  1'b1, 8'h0F, 16'h8000, 5'b00000);
        issue(CMP,  4'd11, 4'd10, 4'd7,  1'b0, 8'h00, 16'h7FFF, 5'b00101);
        issue(MOV,  4'd12, 4'd0,  4'd0,  1'b1, 8'h05, 16'h0005, 5'b00101);
        issue(CMP,  4'd11, 4'd12, 4'd0,  1'b1, 8'h05, 16'h0000, 5'b00010);
        issue(NOP,  4'd12, 4'd12, 4'd12, 1'b0, 8'h00, 16'h0000, 5'b00010);
        issue(XOR_, 4'd13, 4'd12, 4'd12, 1'b0, 8'h00, 16'h0000, 5'b00010);
        issue(OR_,  4'd14, 4'd12, 4'd0,  1'b1, 8'h30, 16'h0035, 5'b00000);
        issue(AND_, 4'd15, 4'd14, 4'd0,  1'b1, 8'h0F, 16'h0005, 5'b00000);
        issue(NOT_, 4'd13, 4'd14, 4'd0,  1'b0, 8'h00, 16'hFFCA, 5'b00000);
        idle(1);
        dbg_chk(4'd8,  16'h0000);
        dbg_chk(4'd9,  16'h0001);
        dbg_chk(4'd10, 16'h8000);
        dbg_chk(4'd11, 16'h0000);
        dbg_chk(4'd12, 16'h0005);
        dbg_chk(4'd13, 16'hFFCA);
        dbg_chk(4'd15, 16'h0005);
        idle(1);

        // Stall with in_valid held high
        bus.stall = 1'b1;
        drive(MOV, 4'd1, 4'd0, 4'd0, 1'b1, 8'h33);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_res_valid", 32'(bus.res_valid), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        dbg_chk(4'd1, 16'h007F);
        idle(1);

        // r0 hardwired to zero, including bypass
        issue(MOV, 4'd0, 4'd0, 4'd0, 1'b1, 8'h05, 16'h0005, 5'b00000);
        issue(ADD, 4'd2, 4'd0, 4'd0, 1'b0, 8'h00, 16'h0000, 5'b00010);
        idle(1);
        dbg_chk(4'd0, 16'h0000);
        dbg_chk(4'd2, 16'h0000);

        for (int c = 0; c < 10 && exp_q.size() != 0; c++) idle(1);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
